// File: rtl/pipelined_seq_alu.sv
// Parametrised ALU with valid/ready handshakes, an iterative shift-add multiplier and a
// one-entry registered result stage. Define ALU_SATURATE_EN to enable opcodes 18/19 (saturating add/sub).
module pipelined_seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       FunSel,
  input  logic             WF,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut
);

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;
  logic [3:0]         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mul_full_q, mul_full_d;
  logic               mul_high_q, mul_high_d;
  logic               mul_wf_q, mul_wf_d;

  function automatic logic [WIDTH-1:0] mask_of(input logic f);
    return f ? {WIDTH{1'b1}} : {{(WIDTH-H){1'b0}}, {H{1'b1}}};
  endfunction

  function automatic logic [WIDTH-1:0] msb_of(input logic f);
    return f ? {1'b1, {(WIDTH-1){1'b0}}} : {{(WIDTH-H){1'b0}}, 1'b1, {(H-1){1'b0}}};
  endfunction

  logic             full, accept, is_mul, is_sub, reserved, cin, carry;
  logic [4:0]       op;
  logic [WIDTH-1:0] mask, msb, a, b, b_op, sum_r;
  logic             a_msb, b_msb, s_msb, add_ovf, sub_ovf;
  logic [WIDTH:0]   sum_w;

  assign full     = FunSel[5];
  assign op       = FunSel[4:0];
  assign mask     = mask_of(full);
  assign msb      = msb_of(full);
  assign a        = A & mask;
  assign b        = B & mask;
  assign a_msb    = |(a & msb);
  assign b_msb    = |(b & msb);
  assign is_mul   = (op == 5'd16) || (op == 5'd17);
`ifdef ALU_SATURATE_EN
  assign is_sub   = (op == 5'd6) || (op == 5'd19);
  assign reserved = (op >= 5'd20);
`else
  assign is_sub   = (op == 5'd6);
  assign reserved = (op >= 5'd18);
`endif

  // Subtraction reuses the adder as A + ~B + 1, so carry means "no borrow".
  assign b_op    = is_sub ? (~B & mask) : b;
  assign cin     = is_sub | ((op == 5'd5) & flags_q[2]);
  assign sum_w   = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
  assign sum_r   = sum_w[WIDTH-1:0] & mask;
  assign carry   = full ? sum_w[WIDTH] : sum_w[H];
  assign s_msb   = |(sum_r & msb);
  assign add_ovf = (a_msb == b_msb) && (s_msb != a_msb);
  assign sub_ovf = (a_msb != b_msb) && (s_msb == b_msb);

`ifdef ALU_SATURATE_EN
  logic             sat_ovf;
  logic [WIDTH-1:0] sat_val;
  assign sat_ovf = is_sub ? sub_ovf : add_ovf;
  assign sat_val = a_msb ? msb : (mask & ~msb);
`endif

  assign accept   = InValid && InReady;
  assign InReady  = (state_q == IDLE) && (!out_valid_q || OutReady);
  assign OutValid = out_valid_q;
  assign ALUOut   = alu_out_q;
  assign FlagsOut = flags_q;

  logic [WIDTH-1:0] res;
  logic             c_new, o_new, upd_c, upd_o;
  logic [3:0]       alu_flags;

  always_comb begin
    res   = '0;
    c_new = 1'b0;
    o_new = 1'b0;
    upd_c = 1'b0;
    upd_o = 1'b0;
    case (op)
      5'd0:  res = a;
      5'd1:  res = b;
      5'd2:  res = ~a & mask;
      5'd3:  res = ~b & mask;
      5'd4, 5'd5: begin
        res = sum_r; c_new = carry; o_new = add_ovf; upd_c = 1'b1; upd_o = 1'b1;
      end
      5'd6: begin
        res = sum_r; c_new = carry; o_new = sub_ovf; upd_c = 1'b1; upd_o = 1'b1;
      end
      5'd7:  res = a & b;
      5'd8:  res = a | b;
      5'd9:  res = a ^ b;
      5'd10: res = ~(a & b) & mask;
      5'd11: begin res = (a << 1) & mask; c_new = a_msb; upd_c = 1'b1; end
      5'd12: begin res = a >> 1; c_new = a[0]; upd_c = 1'b1; end
      5'd13: begin res = (a >> 1) | (a_msb ? msb : '0); c_new = a[0]; upd_c = 1'b1; end
      5'd14: begin
        res = ((a << 1) | {{(WIDTH-1){1'b0}}, a_msb}) & mask; c_new = a_msb; upd_c = 1'b1;
      end
      5'd15: begin res = (a >> 1) | (a[0] ? msb : '0); c_new = a[0]; upd_c = 1'b1; end
`ifdef ALU_SATURATE_EN
      5'd18, 5'd19: begin
        res = sat_ovf ? sat_val : sum_r; c_new = 1'b0; o_new = sat_ovf; upd_c = 1'b1; upd_o = 1'b1;
      end
`endif
      default: ;
    endcase
    alu_flags    = flags_q;
    alu_flags[3] = (res == '0);
    if (op != 5'd13) alu_flags[1] = |(res & msb);
    if (upd_c)       alu_flags[2] = c_new;
    if (upd_o)       alu_flags[0] = o_new;
  end

  logic [2*WIDTH-1:0] prod_nx;
  logic               mul_last;
  logic [WIDTH-1:0]   mul_lo, mul_hi, mul_res;
  logic [3:0]         mul_flags;

  // Half-width products of H-bit operands fit entirely in the low WIDTH bits.
  always_comb begin
    prod_nx      = prod_q + (mplier_q[0] ? mcand_q : '0);
    mul_last     = (cnt_q == (mul_full_q ? CW'(WIDTH-1) : CW'(H-1)));
    mul_lo       = mul_full_q ? prod_nx[WIDTH-1:0] : {{(WIDTH-H){1'b0}}, prod_nx[H-1:0]};
    mul_hi       = mul_full_q ? prod_nx[2*WIDTH-1:WIDTH] : {{(WIDTH-H){1'b0}}, prod_nx[WIDTH-1:H]};
    mul_res      = mul_high_q ? mul_hi : mul_lo;
    mul_flags    = flags_q;
    mul_flags[3] = (mul_res == '0);
    mul_flags[1] = |(mul_res & msb_of(mul_full_q));
    mul_flags[2] = !mul_high_q && (mul_hi != '0);
    mul_flags[0] = !mul_high_q && (mul_hi != '0);
  end

  always_comb begin
    state_d     = state_q;
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    mul_full_d  = mul_full_q;
    mul_high_d  = mul_high_q;
    mul_wf_d    = mul_wf_q;
    if (out_valid_q && OutReady) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d    = MUL;
            mcand_d    = {{WIDTH{1'b0}}, a};
            mplier_d   = b;
            prod_d     = '0;
            cnt_d      = '0;
            mul_full_d = full;
            mul_high_d = op[0];
            mul_wf_d   = WF;
          end else begin
            alu_out_d   = res;
            out_valid_d = 1'b1;
            if (WF && !reserved) flags_d = alu_flags;
          end
        end
      end
      MUL: begin
        prod_d   = prod_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (mul_last) begin
          state_d     = IDLE;
          alu_out_d   = mul_res;
          out_valid_d = 1'b1;
          if (mul_wf_q) flags_d = mul_flags;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      alu_out_q   <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      prod_q      <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      mul_full_q  <= 1'b0;
      mul_high_q  <= 1'b0;
      mul_wf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      mul_full_q  <= mul_full_d;
      mul_high_q  <= mul_high_d;
      mul_wf_q    <= mul_wf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_seq_alu.sv
// Self-checking bench for pipelined_seq_alu (WIDTH=16): directed vectors with literal
// expectations plus an arithmetic reference model compared every cycle.
module tb_pipelined_seq_alu;

  logic        Clock, Reset, InValid, InReady, WF, OutValid, OutReady;
  logic [15:0] A, B, ALUOut;
  logic [5:0]  FunSel;
  logic [3:0]  FlagsOut;

  int n_total = 0;
  int n_pass  = 0;

  pipelined_seq_alu #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .FunSel(FunSel), .WF(WF), .OutValid(OutValid),
    .OutReady(OutReady), .ALUOut(ALUOut), .FlagsOut(FlagsOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference: result and {Z,C,N,O} from signed/unsigned arithmetic on the active width.
  function automatic logic [19:0] ref_op(input logic [5:0] fs, input logic [15:0] ain,
                                         input logic [15:0] bin, input logic [3:0] fl,
                                         input logic wf);
    int wa;
    longint unsigned mask, a, b, r, p, msbv, cin;
    longint sa, sb, sr, smax, smin;
    logic c, o;
    bit tz, tn, tc, to;
    logic [3:0] f;
    wa   = fs[5] ? 16 : 8;
    mask = (64'd1 << wa) - 1;
    msbv = 64'd1 << (wa - 1);
    a    = {48'd0, ain} & mask;
    b    = {48'd0, bin} & mask;
    smax = longint'(msbv) - 1;
    smin = -longint'(msbv);
    sa   = ((a & msbv) != 0) ? longint'(a) - longint'(mask) - 1 : longint'(a);
    sb   = ((b & msbv) != 0) ? longint'(b) - longint'(mask) - 1 : longint'(b);
    cin  = (fs[4:0] == 5'd5 && fl[2]) ? 1 : 0;
    tz = 1; tn = 1; tc = 0; to = 0; c = 0; o = 0; r = 0;
    case (fs[4:0])
      5'd0:  r = a;
      5'd1:  r = b;
      5'd2:  r = ~a & mask;
      5'd3:  r = ~b & mask;
      5'd4, 5'd5: begin
        p = a + b + cin; r = p & mask; c = (p > mask);
        sr = sa + sb + longint'(cin); o = (sr > smax) || (sr < smin); tc = 1; to = 1;
      end
      5'd6: begin
        r = (a - b) & mask; c = (a >= b);
        sr = sa - sb; o = (sr > smax) || (sr < smin); tc = 1; to = 1;
      end
      5'd7:  r = a & b;
      5'd8:  r = a | b;
      5'd9:  r = a ^ b;
      5'd10: r = ~(a & b) & mask;
      5'd11: begin r = (a << 1) & mask; c = ((a & msbv) != 0); tc = 1; end
      5'd12: begin r = a >> 1; c = ((a & 1) != 0); tc = 1; end
      5'd13: begin r = (a >> 1) | (a & msbv); c = ((a & 1) != 0); tc = 1; tn = 0; end
      5'd14: begin r = ((a << 1) & mask) | (((a & msbv) != 0) ? 1 : 0); c = ((a & msbv) != 0); tc = 1; end
      5'd15: begin r = (a >> 1) | ((a & 1) << (wa - 1)); c = ((a & 1) != 0); tc = 1; end
      5'd16: begin p = a * b; r = p & mask; c = ((p >> wa) != 0); o = c; tc = 1; to = 1; end
      5'd17: begin p = a * b; r = p >> wa; c = 0; o = 0; tc = 1; to = 1; end
`ifdef ALU_SATURATE_EN
      5'd18, 5'd19: begin
        sr = (fs[4:0] == 5'd18) ? sa + sb : sa - sb;
        if (sr > smax)      begin r = longint'(smax); o = 1; end
        else if (sr < smin) begin r = msbv; o = 1; end
        else                begin r = longint'(sr) & mask; o = 0; end
        c = 0; tc = 1; to = 1;
      end
`endif
      default: begin tz = 0; tn = 0; r = 0; end
    endcase
    f = fl;
    if (wf) begin
      if (tz) f[3] = (r == 0);
      if (tc) f[2] = c;
      if (tn) f[1] = ((r & msbv) != 0);
      if (to) f[0] = o;
    end
    return {r[15:0], f};
  endfunction

  logic [15:0] m_out;
  logic [3:0]  m_fl;
  logic        m_ov;
  int          m_busy;
  logic [19:0] m_pend;
  bit          started = 0;

  initial begin
    logic rdy, cons, load;
    logic [15:0] nr;
    logic [3:0]  nf;
    m_out = 0; m_fl = 0; m_ov = 0; m_busy = 0; m_pend = 0;
    forever begin
      @(posedge Clock);
      if (Reset) begin
        m_out = 0; m_fl = 0; m_ov = 0; m_busy = 0; started = 1;
      end else begin
        rdy  = (m_busy == 0) && (!m_ov || OutReady);
        cons = m_ov && OutReady;
        load = 0; nr = m_out; nf = m_fl;
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin load = 1; {nr, nf} = m_pend; end
        end else if (InValid && rdy) begin
          if (FunSel[4:1] == 4'b1000) begin
            m_busy = FunSel[5] ? 16 : 8;
            m_pend = ref_op(FunSel, A, B, m_fl, WF);
          end else begin
            load = 1;
            {nr, nf} = ref_op(FunSel, A, B, m_fl, WF);
          end
        end
        if (load) begin m_out = nr; m_fl = nf; m_ov = 1; end
        else if (cons) m_ov = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clock);
      if (started) begin
        chk("model_in_ready", {31'd0, InReady}, {31'd0, (m_busy == 0) && (!m_ov || OutReady)});
        chk("model_out_valid", {31'd0, OutValid}, {31'd0, m_ov});
        chk("model_alu_out", {16'd0, ALUOut}, {16'd0, m_out});
        chk("model_flags", {28'd0, FlagsOut}, {28'd0, m_fl});
      end
    end
  end

  task automatic issue(input logic [5:0] fs, input logic [15:0] a, input logic [15:0] b, input logic w);
    int n = 0;
    FunSel = fs; A = a; B = b; WF = w; InValid = 1'b1;
    @(negedge Clock);
    while (!InReady && n < 50) begin n++; @(negedge Clock); end
    chk("issue_ready", {31'd0, InReady}, 32'd1);
    @(posedge Clock);
    #1 InValid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    @(negedge Clock);
    while (!InReady && n < 40) begin n++; @(negedge Clock); end
  endtask

  initial begin
    logic [15:0] va [4];
    logic [15:0] vb [4];
    int n;
    va = '{16'h7FFF, 16'hA5C3, 16'h0001, 16'hFF80};
    vb = '{16'h8001, 16'h3C96, 16'hFFFF, 16'h0080};
    Reset = 1; InValid = 0; OutReady = 1; A = 0; B = 0; FunSel = 0; WF = 0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("reset_alu_out", {16'd0, ALUOut}, 32'h0);
    chk("reset_flags", {28'd0, FlagsOut}, 32'h0);
    chk("reset_out_valid", {31'd0, OutValid}, 32'h0);
    @(posedge Clock); #1 Reset = 0;

    issue(6'b100100, 16'h7FFF, 16'h0001, 1);
    @(negedge Clock);
    chk("add_ovf_result", {16'd0, ALUOut}, 32'h8000);
    chk("add_ovf_flags", {28'd0, FlagsOut}, 32'b0011);
    chk("add_ovf_valid", {31'd0, OutValid}, 32'd1);

    issue(6'b000110, 16'hAB05, 16'h1206, 1);
    @(negedge Clock);
    chk("half_sub_result", {16'd0, ALUOut}, 32'h00FF);
    chk("half_sub_flags", {28'd0, FlagsOut}, 32'b0010);

    issue(6'b110000, 16'h0300, 16'h0100, 1);
    wait_ready(n);
    chk("mul_busy_cycles", n, 32'd16);
    chk("mul_result", {16'd0, ALUOut}, 32'h0000);
    chk("mul_flags", {28'd0, FlagsOut}, 32'b1101);
    issue(6'b110001, 16'h0300, 16'h0100, 1);
    wait_ready(n);
    chk("mulh_result", {16'd0, ALUOut}, 32'h0003);
    chk("mulh_flags", {28'd0, FlagsOut}, 32'b0000);

    issue(6'b101001, 16'hF0F0, 16'h0FF0, 0);
    OutReady = 0;
    FunSel = 6'b101000; A = 16'h0001; B = 16'h0002; WF = 0; InValid = 1;
    repeat (4) begin
      @(negedge Clock);
      chk("stall_in_ready", {31'd0, InReady}, 32'd0);
      chk("stall_alu_out", {16'd0, ALUOut}, 32'hFF00);
    end
    @(posedge Clock); #1 OutReady = 1;
    @(posedge Clock); #1 InValid = 0;
    @(negedge Clock);
    chk("same_edge_valid", {31'd0, OutValid}, 32'd1);
    chk("same_edge_result", {16'd0, ALUOut}, 32'h0003);

    issue(6'b110000, 16'h0300, 16'h0100, 1);
    repeat (4) @(posedge Clock);
    #1 Reset = 1;
    @(posedge Clock); #1;
    chk("abort_out_valid", {31'd0, OutValid}, 32'd0);
    chk("abort_flags", {28'd0, FlagsOut}, 32'd0);
    chk("abort_alu_out", {16'd0, ALUOut}, 32'd0);
    chk("abort_in_ready", {31'd0, InReady}, 32'd1);
    Reset = 0;
    repeat (30) @(negedge Clock);
    chk("abort_no_stale", {31'd0, OutValid}, 32'd0);

    issue(6'b100110, 16'h0005, 16'h0003, 1);
    @(negedge Clock);
    chk("sub_set_c", {28'd0, FlagsOut}, 32'b0100);
    issue(6'b100101, 16'hFFFF, 16'h0000, 0);
    @(negedge Clock);
    chk("adc_nowf_result", {16'd0, ALUOut}, 32'h0000);
    chk("adc_nowf_flags", {28'd0, FlagsOut}, 32'b0100);
    issue(6'b100101, 16'hFFFF, 16'h0000, 1);
    @(negedge Clock);
    chk("adc_wf_flags", {28'd0, FlagsOut}, 32'b1100);

    issue(6'b001111, 16'h0001, 16'h0000, 1);
    @(negedge Clock);
    chk("ror_half_result", {16'd0, ALUOut}, 32'h0080);
    chk("ror_half_flags", {28'd0, FlagsOut}, 32'b0110);
    issue(6'b101101, 16'h8001, 16'h0000, 1);
    @(negedge Clock);
    chk("asr_full_result", {16'd0, ALUOut}, 32'hC000);
    chk("asr_full_flags", {28'd0, FlagsOut}, 32'b0110);

    for (int op = 0; op < 32; op++)
      for (int f = 0; f < 2; f++)
        for (int k = 0; k < 4; k++)
          issue({f[0], op[4:0]}, va[k], vb[k], op[0] ^ f[0] ^ k[1]);
    repeat (20) @(negedge Clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule

// File: doc/pipelined_seq_alu.md
Name: pipelined_seq_alu

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Operand width is set by a parameter. Each operation can run at full width or half width.
- Adds an iterative shift-add multiplier and valid/ready handshakes on both sides, plus a one-entry registered result stage with an atomic flag commit.
- Sits between register-file read muxes and the write-back path; the control FSM drives it through the handshakes.

Parameters:
- WIDTH, 16, full operand width; must be even and >= 4. H = WIDTH/2.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  operation request valid.
- InReady  out  1  block can accept an operation this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- FunSel  in  6  [5]=1 full width, 0 half width; [4:0] opcode.
- WF  in  1  commit flags for this operation.
- OutValid  out  1  ALUOut holds an unconsumed result.
- OutReady  in  1  consumer takes the result.
- ALUOut  out  WIDTH  registered result.
- FlagsOut  out  4  {Z,C,N,O} = bits [3..0], registered.

Behaviour:
- Reset: ALUOut=0, FlagsOut=0, OutValid=0, state=IDLE, multiplier registers cleared.
- Reset mid-multiply aborts the operation; no result is produced.
- Accept condition: InValid && InReady at a posedge. A, B, FunSel and WF are captured at that edge.
- InReady = (state==IDLE) && (!OutValid || OutReady).
- Consume: OutValid && OutReady at a posedge. OutValid clears unless a new result loads at the same edge.
- Same-edge accept and consume both take effect; OutValid stays 1 with the new result.
- Active width Wa = WIDTH if FunSel[5]=1, else H. Operands are the low Wa bits.
- Result is zero-extended into ALUOut. All flags use the active width; the msb is bit Wa-1.
- Opcodes:
  - 0 A
  - 1 B
  - 2 ~A
  - 3 ~B
  - 4 A+B
  - 5 A+B+C (C = FlagsOut[2] at the accept edge)
  - 6 A-B
  - 7 AND
  - 8 OR
  - 9 XOR
  - 10 NAND
  - 11 LSL
  - 12 LSR
  - 13 ASR
  - 14 ROL
  - 15 ROR
  - 16 MUL (low Wa bits of the unsigned product)
  - 17 MULH (high Wa bits)
  - 18-31 reserved: result 0, flags never written.
- Latency:
  - Opcodes 0-15 and reserved: result and flags load at the accept edge; OutValid=1 the following cycle.
  - 16/17: state IDLE->MUL at accept. A 2*Wa-bit product accumulates one multiplier bit per cycle for Wa cycles. Result loads at the Wa-th edge after accept, state returns to IDLE, InReady=0 throughout MUL.
- Flags (only when captured WF=1; non-listed flags keep their value):
  - Z = (result==0), all non-reserved ops.
  - N = result msb, all non-reserved ops except ASR (N unchanged).
  - C, add/adc: carry out of bit Wa-1.
  - C, sub: carry out of A+~B+1 (1 when A>=B unsigned).
  - C, LSL/ROL: old A msb. LSR/ASR/ROR: old A[0].
  - C and O, MUL: both = (high half != 0). MULH: both cleared.
  - O, add/adc: A,B same sign and result sign differs.
  - O, sub: A,B signs differ and result sign equals B's.
  - Logic ops and ops 0-3: C and O unchanged.
  - ADC carry-in is included in both C and O.
- Back-to-back ADC sees flags written by the immediately preceding op, because the commit happens at that op's accept edge.

Optional Feature:
- ALU_SATURATE_EN defined: opcode 18 = signed saturating add, 19 = signed saturating sub, both at width Wa.
  - On overflow the result clamps to max positive or min negative.
  - O=1 when clamped, C=0; Z and N follow the clamped result.
  - Latency 1.
- Not defined: 18/19 behave as reserved.

Test Plan:
- WIDTH=16, FunSel=6'b100100, A=16'h7FFF, B=1, WF=1 -> next cycle ALUOut=16'h8000, FlagsOut=4'b0011, OutValid=1.
- Half-width sub: FunSel=6'b000110, A=16'hAB05, B=16'h1206 -> ALUOut=16'h00FF, Z=0, C=0, N=1, O=0.
- Full MUL A=16'h0300, B=16'h0100 with WF=1:
  - InReady low for exactly 16 cycles.
  - ALUOut=16'h0000, Z=1, C=1, O=1.
  - MULH on the same operands -> 16'h0003.
- OutReady held 0 with a result pending -> InReady=0 and ALUOut stable.
  - Raising OutReady with InValid=1 consumes and accepts at the same edge; OutValid stays 1.
- Reset asserted 5 cycles into a MUL -> next cycle: state IDLE, OutValid=0, FlagsOut=0, ALUOut=0; no stale result appears later.
- ADC chain with FlagsOut[2]=1 and WF=0: A=16'hFFFF, B=0, opcode 5 -> ALUOut=0, FlagsOut unchanged. Repeat with WF=1 -> Z=1, C=1.
